// File: rtl/unidade_controle_pkg.sv
// State codes shared by the control unit, the datapath top level and the display decoder.
package unidade_controle_pkg;

    localparam int unsigned ESTADO_W = 4;

    typedef logic [ESTADO_W-1:0] estado_t;

    localparam estado_t INICIAL        = 4'h0;
    localparam estado_t PREPARACAO     = 4'h1;
    localparam estado_t INICIO_RODADA  = 4'h2;
    localparam estado_t ESPERA_JOGADA  = 4'h3;
    localparam estado_t REGISTRA       = 4'h4;
    localparam estado_t COMPARA        = 4'h5;
    localparam estado_t PROXIMA_JOGADA = 4'h6;
    localparam estado_t PROXIMA_RODADA = 4'h7;
    localparam estado_t FIM_ACERTOU    = 4'hA;
    localparam estado_t FIM_TIMEOUT    = 4'hD;
    localparam estado_t FIM_ERROU      = 4'hE;

endpackage

// File: rtl/unidade_controle_if.sv
// Control/status bundle between the game control unit (master) and the datapath (slave).
interface unidade_controle_if;
    import unidade_controle_pkg::*;

    logic       iniciar;
    logic [1:0] modo;
    logic       jogada_feita;
    logic       igual;
    logic       fimRodada;
    logic       fimTotal;
    logic       fimT;

    logic       zeraC;
    logic       contaC;
    logic       zeraCL;
    logic       contaCL;
    logic       zeraR;
    logic       registraR;
    logic       conta;
    logic [1:0] configuracao;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    estado_t    db_estado;

    modport master (
        input  iniciar, modo, jogada_feita, igual, fimRodada, fimTotal, fimT,
        output zeraC, contaC, zeraCL, contaCL, zeraR, registraR, conta,
               configuracao, pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        output iniciar, modo, jogada_feita, igual, fimRodada, fimTotal, fimT,
        input  zeraC, contaC, zeraCL, contaCL, zeraR, registraR, conta,
               configuracao, pronto, acertou, errou, timeout, db_estado
    );

endinterface

// File: rtl/unidade_controle.sv
// Moore FSM sequencing a memory game round by round; outputs decode the registered state.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    unidade_controle_if.master   bus
);

    estado_t    state_q, state_d;
    logic [1:0] config_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= INICIAL;
            config_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == PREPARACAO)
                config_q <= bus.modo;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL:        if (bus.iniciar) state_d = PREPARACAO;
            PREPARACAO:     state_d = INICIO_RODADA;
            INICIO_RODADA:  state_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A key press in the same cycle as the timeout still counts as a play.
                if (bus.jogada_feita)
                    state_d = REGISTRA;
                else if (bus.fimT && TIMEOUT_EN)
                    state_d = FIM_TIMEOUT;
            end
            REGISTRA:       state_d = COMPARA;
            COMPARA: begin
                if (!bus.igual)
                    state_d = FIM_ERROU;
                else if (bus.fimRodada && bus.fimTotal)
                    state_d = FIM_ACERTOU;
                else if (bus.fimRodada)
                    state_d = PROXIMA_RODADA;
                else
                    state_d = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: state_d = ESPERA_JOGADA;
            PROXIMA_RODADA: state_d = INICIO_RODADA;
            FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROU:
                if (bus.iniciar) state_d = PREPARACAO;
            default:        state_d = INICIAL;
        endcase
    end

    always_comb begin
        bus.zeraC     = (state_q == PREPARACAO) || (state_q == INICIO_RODADA);
        bus.contaC    = (state_q == PROXIMA_JOGADA);
        bus.zeraCL    = (state_q == PREPARACAO);
        bus.contaCL   = (state_q == PROXIMA_RODADA);
        bus.zeraR     = (state_q == PREPARACAO) || (state_q == INICIO_RODADA);
        bus.registraR = (state_q == REGISTRA);
        bus.conta     = (state_q == ESPERA_JOGADA);
        bus.acertou   = (state_q == FIM_ACERTOU);
        bus.errou     = (state_q == FIM_ERROU);
        bus.timeout   = (state_q == FIM_TIMEOUT);
        bus.pronto    = bus.acertou || bus.errou || bus.timeout;
        bus.configuracao = config_q;
        bus.db_estado    = state_q;
    end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock `clock`, reset `reset`, and no other clock or asynchronous input.
REQ-002 parameter TIMEOUT_EN, default 1, meaning: 1 lets fimT end the game; 0 ignores fimT.
REQ-003 Ports (name  direction  width  meaning):
  clock  in  1  system clock, rising edge
  reset  in  1  synchronous active-high reset
  iniciar  in  1  start request
  modo  in  2  game configuration, sampled at start
  jogada_feita  in  1  datapath pulse: player pressed a key
  igual  in  1  datapath: played value equals memory value
  fimRodada  in  1  datapath: address counter equals round counter
  fimTotal  in  1  datapath: round counter is at the last round
  fimT  in  1  datapath: timeout counter expired
  zeraC, contaC  out  1  clear / increment the address counter
  zeraCL, contaCL  out  1  clear / increment the round counter
  zeraR, registraR  out  1  clear / load the play register
  conta  out  1  enable the timeout counter
  configuracao  out  2  latched modo
  pronto, acertou, errou, timeout  out  1  game status
  db_estado  out  4  current state code

Function
REQ-004 The block SHALL be a Moore FSM; every control output SHALL be a pure decode of the registered state, except configuracao.
REQ-005 States and codes: inicial=0, preparacao=1, inicio_rodada=2, espera_jogada=3, registra=4, compara=5, proxima_jogada=6, proxima_rodada=7, fim_acertou=A, fim_timeout=D, fim_errou=E.
REQ-006 inicial: all outputs 0. If iniciar=1, next state is preparacao; otherwise the FSM stays in inicial.
REQ-007 preparacao: assert zeraC, zeraCL and zeraR. configuracao SHALL load modo on the edge that leaves this state. Next state is inicio_rodada.
REQ-008 inicio_rodada: assert zeraC and zeraR. Next state is espera_jogada.
REQ-009 espera_jogada: assert conta.
  - jogada_feita=1: next state is registra.
  - Else fimT=1 and TIMEOUT_EN=1: next state is fim_timeout.
  - Otherwise stay in espera_jogada.
  - If jogada_feita and fimT are both 1 in the same cycle, jogada_feita wins.
REQ-010 registra: assert registraR. Next state is compara.
REQ-011 compara: all control outputs 0. Next state, in priority order:
  - igual=0: fim_errou.
  - fimRodada=1 and fimTotal=1: fim_acertou.
  - fimRodada=1 (fimTotal=0): proxima_rodada.
  - Otherwise: proxima_jogada.
REQ-012 proxima_jogada: assert contaC for exactly one cycle. Next state is espera_jogada.
REQ-013 proxima_rodada: assert contaCL for exactly one cycle. Next state is inicio_rodada.
REQ-014 Terminal states:
  - fim_acertou asserts pronto and acertou.
  - fim_errou asserts pronto and errou.
  - fim_timeout asserts pronto and timeout.
  - In each terminal state, iniciar=1 gives next state preparacao; otherwise the state holds.
REQ-015 contaCL SHALL never be asserted when fimTotal=1 in compara, so the round counter never wraps.
REQ-016 Response latency: the state changes on the first rising edge after the qualifying input is sampled high. Inputs SHALL NOT be registered internally.
REQ-017 At most one of acertou, errou and timeout SHALL be 1 at any time.
REQ-018 db_estado SHALL equal the current state code.

Reset
REQ-019 When reset=1 at a rising edge, next state is inicial, regardless of state or other inputs, including mid-round.
REQ-020 After reset: all control and status outputs are 0, configuracao=00, and db_estado=0.
REQ-021 Reset SHALL take priority over iniciar in the same cycle.

Structure
REQ-022 The state codes and their width (4 bits) SHALL live in a shared include or package, so the datapath top level and the display decoder use identical values.
REQ-023 The block SHALL be one module: state register, next-state logic, output decode and the 2-bit configuracao register. No sub-module is required.

Verification
REQ-024 Reset, then iniciar=1 for 1 cycle -> db_estado sequence 0,1,2,3, with configuracao=modo from the preparacao cycle.
REQ-025 modo=01, last round:
  - Stimulus: in compara, drive fimRodada=1, fimTotal=1, igual=1.
  - Response: db_estado=A, pronto=1, acertou=1, and contaCL never pulsed in that pass.
REQ-026 First play wrong: igual=0 at compara -> db_estado=E, errou=1 held until iniciar; then iniciar=1 -> db_estado=1.
REQ-027 Timeout:
  - Stimulus: stay in espera_jogada with fimT=1 and TIMEOUT_EN=1.
  - Response: db_estado=D and timeout=1.
  - With TIMEOUT_EN=0, the state remains 3.
  - With fimT and jogada_feita both 1 in the same cycle, next state is 4.
REQ-028 Round advance: in compara, igual=1, fimRodada=1, fimTotal=0 -> contaCL single-cycle pulse in state 7, then states 2 and 3, with zeraC and zeraR high in state 2.
REQ-029 Reset mid-play: reset=1 while db_estado=3 -> db_estado=0 and all outputs 0 on the next edge.
